agex_stage: RTL and testbench
=============================

Name: agex_stage

Overview:
- Address-generation/execute stage; sits directly upstream of the memory stage and feeds its input latch.
- Computes ALU results, load/store addresses, store data and branch/jump resolution, and registers them into the AGEX output latch.
- Multiply runs on an iterative shift-add unit that stalls fetch/decode while busy. Fetch is predicted not-taken, so every taken control transfer raises a registered redirect.

Parameters:
- DATA_W, 32, datapath width; also the multiply iteration count.
- REGNO_W, 5, register-number width.
- OP_W, 5, opcode width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  decoded instruction present
- in_op  in  OP_W  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 LUI, 11 AUIPC, 12 JAL, 13 JALR, 14 BEQ, 15 BNE, 16 BLT, 17 BGE, 18 BLTU, 19 BGEU, 20 LW, 21 SW, 22 MUL, 23 DIVU, 24 REMU; others illegal
- in_src2_imm  in  1  operand B = in_imm instead of in_rs2_val
- in_pc, in_rs1_val, in_rs2_val, in_imm  in  DATA_W each  PC, operands, sign-extended immediate
- in_wregno  in  REGNO_W  destination register
- in_wr_reg  in  1  instruction writes the register file
- stall_out  out  1  hold fetch/decode this cycle
- out_valid, out_wr_reg, out_rd_mem, out_wr_mem  out  1 each  latched control
- out_op  out  OP_W  latched opcode
- out_pc, out_aluout, out_memaddr, out_wr_val  out  DATA_W each  latched PC, result, address, store data
- out_wregno  out  REGNO_W  latched destination
- br_redirect  out  1  registered one-cycle redirect to fetch
- br_target  out  DATA_W  registered redirect target

Behaviour:
- Reset: every out_* = 0, br_redirect = 0, br_target = 0, FSM = IDLE, counter = 0. Reset during BUSY abandons the multiply; no result is ever written for it.
- Single-cycle ops: on an edge with in_valid=1 and FSM=IDLE, the latch loads results and out_valid=1 (latency 1). With in_valid=0 the latch loads a bubble (out_valid=0, all controls 0).
- Arithmetic is modulo 2^DATA_W.
  - B = in_src2_imm ? in_imm : in_rs2_val.
  - Shifts use B[4:0].
  - SLT is signed and SLTU unsigned; both give result 1 or 0.
  - LUI result = in_imm; AUIPC result = in_pc + in_imm.
- Loads/stores: LW/SW memaddr = rs1 + in_imm. SW wr_val = in_rs2_val.
  - LW sets out_rd_mem=1; SW sets out_wr_mem=1 and forces out_wr_reg=0.
- Branches: condition is compared on rs1 vs rs2. Branch target = in_pc + in_imm; branches force out_wr_reg=0.
- Jumps: JAL target = in_pc + in_imm; JALR target = (rs1 + in_imm) with bit0 cleared. Jump result (aluout) = in_pc + 4.
- Redirect: a taken branch or any jump sets br_redirect=1 with br_target at the same edge as the latch load. br_redirect is cleared on the next edge unless another redirect occurs.
- Illegal op: out_valid=1, out_wr_reg=0, no memory access, aluout = 0.
- MUL FSM, states IDLE and BUSY:
  - IDLE with valid MUL: stall_out=1 combinationally. At the edge the FSM enters BUSY, counter=0, multiplicand/multiplier/accumulator are loaded, and the latch loads a bubble.
  - BUSY: one shift-add step per cycle and counter++. Input is ignored.
  - stall_out=1 while counter < DATA_W-1; stall_out=0 when counter == DATA_W-1.
  - At the edge ending the counter == DATA_W-1 cycle: latch loads the low DATA_W bits of the product, out_valid=1, FSM returns to IDLE.
  - Result appears DATA_W+1 edges after MUL is first presented. A back-to-back MUL restarts immediately from IDLE.
- stall_out is 0 in all other cases.

Optional Feature:
- Macro AGEX_DIV_EN.
- Defined: DIVU/REMU use the same FSM as a restoring divider, DATA_W iterations, identical stall/latency rules. Divide-by-zero gives DIVU = all ones and REMU = dividend.
- Undefined: DIVU/REMU are treated as illegal ops (single cycle, aluout 0, out_wr_reg 0, no stall).

Test Plan:
- ADD rs1=0x7FFFFFFF, rs2=1, wregno=3 -> next edge out_valid=1, out_aluout=0x80000000, out_wregno=3, out_wr_reg=1.
- SW rs1=0x100, imm=-4, rs2=0xDEAD -> out_memaddr=0xFC, out_wr_val=0xDEAD, out_wr_mem=1, out_wr_reg=0.
- BNE pc=0x40, rs1=1, rs2=2, imm=0x10 -> br_redirect=1 for exactly one cycle, br_target=0x50. Same test with rs1=rs2 -> br_redirect stays 0.
- MUL 0xFFFF x 0x10001 -> stall_out=1 for 32 cycles, then 0; out_aluout=0xFFFFFFFF exactly 33 edges after first presentation; bubbles in between.
- Reset asserted mid-MUL (counter=10) -> next edge FSM=IDLE, stall_out=0, all outputs 0; no MUL result emitted afterwards.
- AGEX_DIV_EN defined: DIVU 100/7 -> 14; REMU 100/0 -> 100. Undefined: DIVU -> aluout 0, out_wr_reg=0, no stall.

Source files
------------

// File: rtl/agex_stage_if.sv
// AGEX stage bus: decoded instruction in, AGEX latch out.
// master = decode/mem side, slave = agex_stage.
interface agex_stage_if #(
    parameter int DATA_W  = 32,
    parameter int REGNO_W = 5,
    parameter int OP_W    = 5
);
    logic               in_valid;
    logic [OP_W-1:0]    in_op;
    logic               in_src2_imm;
    logic [DATA_W-1:0]  in_pc;
    logic [DATA_W-1:0]  in_rs1_val;
    logic [DATA_W-1:0]  in_rs2_val;
    logic [DATA_W-1:0]  in_imm;
    logic [REGNO_W-1:0] in_wregno;
    logic               in_wr_reg;

    logic               stall_out;
    logic               out_valid;
    logic               out_wr_reg;
    logic               out_rd_mem;
    logic               out_wr_mem;
    logic [OP_W-1:0]    out_op;
    logic [DATA_W-1:0]  out_pc;
    logic [DATA_W-1:0]  out_aluout;
    logic [DATA_W-1:0]  out_memaddr;
    logic [DATA_W-1:0]  out_wr_val;
    logic [REGNO_W-1:0] out_wregno;
    logic               br_redirect;
    logic [DATA_W-1:0]  br_target;

    modport master (
        output in_valid, in_op, in_src2_imm, in_pc,
        output in_rs1_val, in_rs2_val, in_imm,
        output in_wregno, in_wr_reg,
        input  stall_out, out_valid, out_wr_reg,
        input  out_rd_mem, out_wr_mem, out_op, out_pc,
        input  out_aluout, out_memaddr, out_wr_val,
        input  out_wregno, br_redirect, br_target
    );

    modport slave (
        input  in_valid, in_op, in_src2_imm, in_pc,
        input  in_rs1_val, in_rs2_val, in_imm,
        input  in_wregno, in_wr_reg,
        output stall_out, out_valid, out_wr_reg,
        output out_rd_mem, out_wr_mem, out_op, out_pc,
        output out_aluout, out_memaddr, out_wr_val,
        output out_wregno, br_redirect, br_target
    );
endinterface

// File: rtl/agex_stage.sv
// AGEX stage: ALU, address gen, branch resolve, iterative MUL.
// Define AGEX_DIV_EN to add DIVU/REMU on the iterative unit.
module agex_stage #(
    parameter int DATA_W  = 32,
    parameter int REGNO_W = 5,
    parameter int OP_W    = 5
) (
    input logic       clk,
    input logic       reset,
    agex_stage_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_XOR  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_SLT  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SLTU = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SLL  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_SRL  = OP_W'(8);
    localparam logic [OP_W-1:0] OP_SRA  = OP_W'(9);
    localparam logic [OP_W-1:0] OP_LUI  = OP_W'(10);
    localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(11);
    localparam logic [OP_W-1:0] OP_JAL  = OP_W'(12);
    localparam logic [OP_W-1:0] OP_JALR = OP_W'(13);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(14);
    localparam logic [OP_W-1:0] OP_BNE  = OP_W'(15);
    localparam logic [OP_W-1:0] OP_BLT  = OP_W'(16);
    localparam logic [OP_W-1:0] OP_BGE  = OP_W'(17);
    localparam logic [OP_W-1:0] OP_BLTU = OP_W'(18);
    localparam logic [OP_W-1:0] OP_BGEU = OP_W'(19);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(20);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(21);
    localparam logic [OP_W-1:0] OP_MUL  = OP_W'(22);
`ifdef AGEX_DIV_EN
    localparam logic [OP_W-1:0] OP_DIVU = OP_W'(23);
    localparam logic [OP_W-1:0] OP_REMU = OP_W'(24);
`endif

    typedef enum logic { IDLE, BUSY } state_t;
    typedef enum logic [1:0] { IT_MUL, IT_DIV, IT_REM } iter_t;

    state_t             state;
    iter_t              kind;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  mcand;
    logic [DATA_W-1:0]  mplier;
    logic [DATA_W-1:0]  acc;
    logic [OP_W-1:0]    it_op;
    logic [DATA_W-1:0]  it_pc;
    logic [REGNO_W-1:0] it_wregno;
    logic               it_wr_reg;

    logic [DATA_W-1:0]  b;
    logic [DATA_W-1:0]  rs1;
    logic [DATA_W-1:0]  rs2;
    logic [DATA_W-1:0]  pc;
    logic [DATA_W-1:0]  sum_ri;
    logic [DATA_W-1:0]  pc_imm;
    logic [DATA_W-1:0]  res;
    logic [DATA_W-1:0]  addr;
    logic [DATA_W-1:0]  st_val;
    logic [DATA_W-1:0]  tgt;
    logic               wr;
    logic               rd_m;
    logic               wr_m;
    logic               take;
    logic               is_iter;
    iter_t              in_kind;

    logic [DATA_W:0]    shifted;
    logic               ge;
    logic [DATA_W-1:0]  diff;
    logic [DATA_W-1:0]  mul_acc;
    logic [DATA_W-1:0]  nxt_acc;
    logic [DATA_W-1:0]  nxt_mcand;
    logic [DATA_W-1:0]  nxt_mplier;
    logic [DATA_W-1:0]  fin;

    // Single-cycle decode and execute of the presented instruction
    always_comb begin
        rs1     = bus.in_rs1_val;
        rs2     = bus.in_rs2_val;
        pc      = bus.in_pc;
        b       = bus.in_src2_imm ? bus.in_imm : rs2;
        sum_ri  = rs1 + bus.in_imm;
        pc_imm  = pc + bus.in_imm;
        res     = '0;
        addr    = '0;
        st_val  = '0;
        tgt     = pc_imm;
        wr      = bus.in_wr_reg;
        rd_m    = 1'b0;
        wr_m    = 1'b0;
        take    = 1'b0;
        is_iter = 1'b0;
        in_kind = IT_MUL;
        case (bus.in_op)
            OP_ADD:   res = rs1 + b;
            OP_SUB:   res = rs1 - b;
            OP_AND:   res = rs1 & b;
            OP_OR:    res = rs1 | b;
            OP_XOR:   res = rs1 ^ b;
            OP_SLT:   res = DATA_W'($signed(rs1) < $signed(b));
            OP_SLTU:  res = DATA_W'(rs1 < b);
            OP_SLL:   res = rs1 << b[4:0];
            OP_SRL:   res = rs1 >> b[4:0];
            OP_SRA:   res = $signed(rs1) >>> b[4:0];
            OP_LUI:   res = bus.in_imm;
            OP_AUIPC: res = pc_imm;
            OP_JAL: begin
                res  = pc + DATA_W'(4);
                take = 1'b1;
            end
            OP_JALR: begin
                res  = pc + DATA_W'(4);
                take = 1'b1;
                tgt  = {sum_ri[DATA_W-1:1], 1'b0};
            end
            OP_BEQ:  begin wr = 1'b0; take = rs1 == rs2; end
            OP_BNE:  begin wr = 1'b0; take = rs1 != rs2; end
            OP_BLT:  begin wr = 1'b0; take = $signed(rs1) < $signed(rs2); end
            OP_BGE:  begin wr = 1'b0; take = $signed(rs1) >= $signed(rs2); end
            OP_BLTU: begin wr = 1'b0; take = rs1 < rs2; end
            OP_BGEU: begin wr = 1'b0; take = rs1 >= rs2; end
            OP_LW: begin
                addr = sum_ri;
                rd_m = 1'b1;
            end
            OP_SW: begin
                addr   = sum_ri;
                st_val = rs2;
                wr_m   = 1'b1;
                wr     = 1'b0;
            end
            OP_MUL: is_iter = 1'b1;
`ifdef AGEX_DIV_EN
            OP_DIVU: begin is_iter = 1'b1; in_kind = IT_DIV; end
            OP_REMU: begin is_iter = 1'b1; in_kind = IT_REM; end
`endif
            default: wr = 1'b0;
        endcase
    end

    // One shift-add (MUL) or restoring-divide step per cycle
    always_comb begin
        shifted = {acc, mplier[DATA_W-1]};
        ge      = shifted >= {1'b0, mcand};
        diff    = shifted[DATA_W-1:0] - mcand;
        mul_acc = acc + (mplier[0] ? mcand : '0);
        if (kind == IT_MUL) begin
            nxt_acc    = mul_acc;
            nxt_mcand  = mcand << 1;
            nxt_mplier = mplier >> 1;
        end else begin
            nxt_acc    = ge ? diff : shifted[DATA_W-1:0];
            nxt_mcand  = mcand;
            nxt_mplier = {mplier[DATA_W-2:0], ge};
        end
        case (kind)
            IT_MUL:  fin = mul_acc;
            IT_DIV:  fin = nxt_mplier;
            default: fin = nxt_acc;
        endcase
    end

    // Hold fetch/decode until the last iteration cycle
    assign bus.stall_out = (state == IDLE) ? (bus.in_valid && is_iter)
                                           : (cnt != LAST);

    // Iteration FSM plus AGEX output latch and redirect
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            kind            <= IT_MUL;
            cnt             <= '0;
            mcand           <= '0;
            mplier          <= '0;
            acc             <= '0;
            it_op           <= '0;
            it_pc           <= '0;
            it_wregno       <= '0;
            it_wr_reg       <= 1'b0;
            bus.out_valid   <= 1'b0;
            bus.out_wr_reg  <= 1'b0;
            bus.out_rd_mem  <= 1'b0;
            bus.out_wr_mem  <= 1'b0;
            bus.out_op      <= '0;
            bus.out_pc      <= '0;
            bus.out_aluout  <= '0;
            bus.out_memaddr <= '0;
            bus.out_wr_val  <= '0;
            bus.out_wregno  <= '0;
            bus.br_redirect <= 1'b0;
            bus.br_target   <= '0;
        end else begin
            bus.out_valid   <= 1'b0;
            bus.out_wr_reg  <= 1'b0;
            bus.out_rd_mem  <= 1'b0;
            bus.out_wr_mem  <= 1'b0;
            bus.out_op      <= '0;
            bus.out_pc      <= '0;
            bus.out_aluout  <= '0;
            bus.out_memaddr <= '0;
            bus.out_wr_val  <= '0;
            bus.out_wregno  <= '0;
            bus.br_redirect <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid && is_iter) begin
                        state     <= BUSY;
                        kind      <= in_kind;
                        cnt       <= '0;
                        acc       <= '0;
                        mcand     <= (in_kind == IT_MUL) ? rs1 : b;
                        mplier    <= (in_kind == IT_MUL) ? b : rs1;
                        it_op     <= bus.in_op;
                        it_pc     <= pc;
                        it_wregno <= bus.in_wregno;
                        it_wr_reg <= bus.in_wr_reg;
                    end else if (bus.in_valid) begin
                        bus.out_valid   <= 1'b1;
                        bus.out_wr_reg  <= wr;
                        bus.out_rd_mem  <= rd_m;
                        bus.out_wr_mem  <= wr_m;
                        bus.out_op      <= bus.in_op;
                        bus.out_pc      <= pc;
                        bus.out_aluout  <= res;
                        bus.out_memaddr <= addr;
                        bus.out_wr_val  <= st_val;
                        bus.out_wregno  <= bus.in_wregno;
                        bus.br_redirect <= take;
                        if (take) bus.br_target <= tgt;
                    end
                end
                default: begin
                    acc    <= nxt_acc;
                    mcand  <= nxt_mcand;
                    mplier <= nxt_mplier;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state          <= IDLE;
                        bus.out_valid  <= 1'b1;
                        bus.out_wr_reg <= it_wr_reg;
                        bus.out_op     <= it_op;
                        bus.out_pc     <= it_pc;
                        bus.out_aluout <= fin;
                        bus.out_wregno <= it_wregno;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_agex_stage.sv
// Directed-vector bench for agex_stage.
// Build with +define+AGEX_DIV_EN to cover the divider.
module tb_agex_stage;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_bad;

    agex_stage_if #(.DATA_W(32), .REGNO_W(5), .OP_W(5)) bus ();

    agex_stage #(.DATA_W(32), .REGNO_W(5), .OP_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic src2_imm,
                         input logic [4:0] wregno);
        bus.in_valid    = 1'b1;
        bus.in_op       = op;
        bus.in_pc       = pc;
        bus.in_rs1_val  = rs1;
        bus.in_rs2_val  = rs2;
        bus.in_imm      = imm;
        bus.in_src2_imm = src2_imm;
        bus.in_wregno   = wregno;
        bus.in_wr_reg   = 1'b1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_op    = '0;
    endtask

    task automatic alu(input string tag, input logic [4:0] op,
                       input logic [31:0] rs1, input logic [31:0] b,
                       input logic src2_imm, input logic [31:0] exp);
        drive(op, 32'h1000, rs1, src2_imm ? 32'h0 : b,
              src2_imm ? b : 32'h0, src2_imm, 5'd1);
        tick();
        chk(tag, bus.out_aluout, exp);
    endtask

    // Present an iterative op and track stall/bubble/latency
    task automatic run_iter(input string tag, input logic [4:0] op,
                            input logic [31:0] rs1, input logic [31:0] rs2,
                            input logic [31:0] exp);
        int stalls;
        int valids;
        stalls = 0;
        valids = 0;
        drive(op, 32'h80, rs1, rs2, 32'h0, 1'b0, 5'd9);
        #1;
        if (bus.stall_out) stalls++;
        for (int k = 1; k <= 33; k++) begin
            tick();
            idle();
            #1;
            if (k < 33) begin
                if (bus.stall_out) stalls++;
                if (bus.out_valid) valids++;
            end
        end
        chk({tag, "_stalls"}, 32'(stalls), 32'd32);
        chk({tag, "_bubbles"}, 32'(valids), 32'd0);
        chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        chk({tag, "_res"}, bus.out_aluout, exp);
        chk({tag, "_wregno"}, {27'd0, bus.out_wregno}, 32'd9);
        chk({tag, "_stall_end"}, {31'd0, bus.stall_out}, 32'd0);
    endtask

    initial begin
        int late;
        n_vec = 0;
        n_bad = 0;
        reset = 1'b1;
        bus.in_wr_reg   = 1'b0;
        bus.in_src2_imm = 1'b0;
        bus.in_pc       = '0;
        bus.in_rs1_val  = '0;
        bus.in_rs2_val  = '0;
        bus.in_imm      = '0;
        bus.in_wregno   = '0;
        idle();
        tick();
        tick();
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_alu", bus.out_aluout, 32'd0);
        chk("rst_redir", {31'd0, bus.br_redirect}, 32'd0);
        chk("rst_stall", {31'd0, bus.stall_out}, 32'd0);
        reset = 1'b0;
        tick();

        drive(5'd0, 32'h0, 32'h7FFF_FFFF, 32'h1, 32'h0, 1'b0, 5'd3);
        tick();
        chk("add_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("add_res", bus.out_aluout, 32'h8000_0000);
        chk("add_wregno", {27'd0, bus.out_wregno}, 32'd3);
        chk("add_wr", {31'd0, bus.out_wr_reg}, 32'd1);

        drive(5'd21, 32'h0, 32'h100, 32'hDEAD, 32'hFFFF_FFFC, 1'b1, 5'd0);
        tick();
        chk("sw_addr", bus.out_memaddr, 32'hFC);
        chk("sw_val", bus.out_wr_val, 32'hDEAD);
        chk("sw_wmem", {31'd0, bus.out_wr_mem}, 32'd1);
        chk("sw_wr", {31'd0, bus.out_wr_reg}, 32'd0);

        drive(5'd20, 32'h0, 32'h10, 32'h0, 32'h8, 1'b1, 5'd4);
        tick();
        chk("lw_addr", bus.out_memaddr, 32'h18);
        chk("lw_rmem", {31'd0, bus.out_rd_mem}, 32'd1);

        drive(5'd15, 32'h40, 32'h1, 32'h2, 32'h10, 1'b1, 5'd0);
        tick();
        chk("bne_redir", {31'd0, bus.br_redirect}, 32'd1);
        chk("bne_tgt", bus.br_target, 32'h50);
        chk("bne_wr", {31'd0, bus.out_wr_reg}, 32'd0);
        idle();
        tick();
        chk("bne_redir_clr", {31'd0, bus.br_redirect}, 32'd0);
        drive(5'd15, 32'h40, 32'h2, 32'h2, 32'h10, 1'b1, 5'd0);
        tick();
        chk("bne_nt", {31'd0, bus.br_redirect}, 32'd0);

        drive(5'd13, 32'h200, 32'h103, 32'h0, 32'h0, 1'b1, 5'd1);
        tick();
        chk("jalr_res", bus.out_aluout, 32'h204);
        chk("jalr_redir", {31'd0, bus.br_redirect}, 32'd1);
        chk("jalr_tgt", bus.br_target, 32'h102);

        alu("sub", 5'd1, 32'd5, 32'd7, 1'b0, 32'hFFFF_FFFE);
        alu("slt", 5'd5, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd1);
        alu("sltu", 5'd6, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0);
        alu("sra", 5'd9, 32'h8000_0000, 32'd4, 1'b1, 32'hF800_0000);
        alu("sll", 5'd7, 32'd3, 32'h21, 1'b1, 32'd6);
        alu("lui", 5'd10, 32'd0, 32'h1234_5000, 1'b1, 32'h1234_5000);
        alu("auipc", 5'd11, 32'd0, 32'h20, 1'b1, 32'h1020);

        drive(5'd31, 32'h0, 32'h5, 32'h5, 32'h0, 1'b0, 5'd2);
        tick();
        chk("ill_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("ill_res", bus.out_aluout, 32'd0);
        chk("ill_wr", {31'd0, bus.out_wr_reg}, 32'd0);

        run_iter("mul", 5'd22, 32'hFFFF, 32'h1_0001, 32'hFFFF_FFFF);
        run_iter("mul2", 5'd22, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);

`ifdef AGEX_DIV_EN
        run_iter("divu", 5'd23, 32'd100, 32'd7, 32'd14);
        run_iter("remu_z", 5'd24, 32'd100, 32'd0, 32'd100);
`else
        drive(5'd23, 32'h0, 32'd100, 32'd7, 32'h0, 1'b0, 5'd2);
        #1;
        chk("divu_stall", {31'd0, bus.stall_out}, 32'd0);
        tick();
        chk("divu_res", bus.out_aluout, 32'd0);
        chk("divu_wr", {31'd0, bus.out_wr_reg}, 32'd0);
        chk("divu_valid", {31'd0, bus.out_valid}, 32'd1);
`endif

        drive(5'd22, 32'h0, 32'h3, 32'h5, 32'h0, 1'b0, 5'd6);
        for (int k = 1; k <= 11; k++) begin
            tick();
            idle();
        end
        reset = 1'b1;
        tick();
        chk("rmul_stall", {31'd0, bus.stall_out}, 32'd0);
        chk("rmul_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rmul_res", bus.out_aluout, 32'd0);
        reset = 1'b0;
        late = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.out_valid || bus.stall_out) late++;
        end
        chk("rmul_no_result", 32'(late), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
